wb_arbiter_queue: RTL and testbench

// - Writeback stage ahead of the 5-to-32 register select decoder and the register file.
// - Arbitrates writeback requests from ALU and LSU (round-robin) and buffers them in an in-order queue.
// - Drains one entry per accepted cycle as {rd, data}; wb_rd_out drives the decoder address input.
// - Reports per-source-register pending status so issue logic can stall on RAW hazards.

---
 rtl/core101_pkg.sv | 18 +
 rtl/fifo_sync.sv | 64 ++++++
 rtl/wb_arbiter_queue.sv | 120 ++++++++++++
 tb/tb_wb_arbiter_queue.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core101_pkg.sv
// Shared writeback-stage definitions: datapath widths, arbiter grant encoding
// and the queued writeback entry layout.
package core101_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LSU = 1'b1
    } grant_e;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/fifo_sync.sv
// In-order circular queue with per-entry valid bits and a tap of each entry's
// upper field, so the owner can compare queued destinations without popping.
module fifo_sync #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37,
    parameter int TAP_W = 5
) (
    input  logic                        clock_in,
    input  logic                        reset_in,
    input  logic                        push,
    input  logic                        pop,
    input  logic [WIDTH-1:0]            push_data,
    output logic [WIDTH-1:0]            head_data,
    output logic                        full,
    output logic                        empty,
    output logic [DEPTH-1:0]            entry_valid,
    output logic [DEPTH-1:0][TAP_W-1:0] entry_tap
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PW-1:0]               rd_ptr;
    logic [PW-1:0]               wr_ptr;
    logic [CW-1:0]               count;

    // On a pop-through of a full queue both pointers address the same slot;
    // the push assignment comes last so the slot stays valid with new data.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            mem         <= '0;
            entry_valid <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            if (pop) begin
                entry_valid[rd_ptr] <= 1'b0;
                rd_ptr              <= rd_ptr + PW'(1);
            end
            if (push) begin
                mem[wr_ptr]         <= push_data;
                entry_valid[wr_ptr] <= 1'b1;
                wr_ptr              <= wr_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // When empty, the slot just behind rd_ptr still holds the last popped
    // entry and cannot be overwritten before the next push lands at rd_ptr.
    assign head_data = empty ? mem[rd_ptr - PW'(1)] : mem[rd_ptr];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_tap[i] = mem[i][WIDTH-1 -: TAP_W];
        end
    end

endmodule

// File: rtl/wb_arbiter_queue.sv
// Writeback stage: round-robin ALU/LSU arbitration into an in-order queue that
// drains to the register file, plus RAW pending flags for the issue stage.
module wb_arbiter_queue #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 4
) (
    input  logic              clock_in,
    input  logic              reset_in,
    input  logic              alu_valid_in,
    output logic              alu_ready_out,
    input  logic [REG_AW-1:0] alu_rd_in,
    input  logic [XLEN-1:0]   alu_data_in,
    input  logic              lsu_valid_in,
    output logic              lsu_ready_out,
    input  logic [REG_AW-1:0] lsu_rd_in,
    input  logic [XLEN-1:0]   lsu_data_in,
    output logic              wb_valid_out,
    input  logic              wb_ready_in,
    output logic [REG_AW-1:0] wb_rd_out,
    output logic [XLEN-1:0]   wb_data_out,
    input  logic [REG_AW-1:0] rs1_addr_in,
    input  logic [REG_AW-1:0] rs2_addr_in,
    output logic              rs1_pending_out,
    output logic              rs2_pending_out
);

    import core101_pkg::*;

    localparam int WIDTH = REG_AW + XLEN;

    grant_e                      grant;
    grant_e                      last_grant;
    logic                        any_req;
    logic [REG_AW-1:0]           win_rd;
    logic [XLEN-1:0]             win_data;
    logic                        win_is_x0;
    logic                        accept;
    logic                        push;
    logic                        pop;
    logic                        q_full;
    logic                        q_empty;
    logic [WIDTH-1:0]            head_data;
    logic [DEPTH-1:0]            entry_valid;
    logic [DEPTH-1:0][REG_AW-1:0] entry_rd;

    // Round-robin: a lone requester always wins, a tie goes to whoever did
    // not win the last accepted transfer.
    always_comb begin
        grant = GRANT_ALU;
        if (alu_valid_in && lsu_valid_in) begin
            grant = (last_grant == GRANT_ALU) ? GRANT_LSU : GRANT_ALU;
        end else if (lsu_valid_in) begin
            grant = GRANT_LSU;
        end
    end

    assign any_req   = alu_valid_in | lsu_valid_in;
    assign win_rd    = (grant == GRANT_ALU) ? alu_rd_in : lsu_rd_in;
    assign win_data  = (grant == GRANT_ALU) ? alu_data_in : lsu_data_in;
    assign win_is_x0 = (win_rd == '0);
    assign pop       = wb_valid_out & wb_ready_in;

    // x0 writes are discarded, so they need no queue space to be accepted.
    assign accept = reset_in & any_req & (win_is_x0 | ~q_full | pop);
    assign push   = accept & ~win_is_x0;

    assign alu_ready_out = accept & (grant == GRANT_ALU);
    assign lsu_ready_out = accept & (grant == GRANT_LSU);

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            last_grant <= GRANT_LSU;
        end else if (accept) begin
            last_grant <= grant;
        end
    end

    fifo_sync #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .TAP_W (REG_AW)
    ) u_queue (
        .clock_in    (clock_in),
        .reset_in    (reset_in),
        .push        (push),
        .pop         (pop),
        .push_data   ({win_rd, win_data}),
        .head_data   (head_data),
        .full        (q_full),
        .empty       (q_empty),
        .entry_valid (entry_valid),
        .entry_tap   (entry_rd)
    );

    assign wb_valid_out = ~q_empty;
    assign wb_rd_out    = head_data[WIDTH-1 -: REG_AW];
    assign wb_data_out  = head_data[XLEN-1:0];

    // x0 is never a hazard even if it were somehow present in the queue.
    always_comb begin
        rs1_pending_out = 1'b0;
        rs2_pending_out = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entry_rd[i] == rs1_addr_in)) begin
                rs1_pending_out = 1'b1;
            end
            if (entry_valid[i] && (entry_rd[i] == rs2_addr_in)) begin
                rs2_pending_out = 1'b1;
            end
        end
        if (rs1_addr_in == '0) begin
            rs1_pending_out = 1'b0;
        end
        if (rs2_addr_in == '0) begin
            rs2_pending_out = 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter_queue.sv
// Bench for wb_arbiter_queue: fixed vector table, directed corner sequences and
// random producer traffic checked against a queue-based reference model.
module tb_wb_arbiter_queue;

    import core101_pkg::*;

    localparam int DEPTH = 4;

    logic              clock_in;
    logic              reset_in;
    logic              alu_valid_in;
    logic              alu_ready_out;
    logic [REG_AW-1:0] alu_rd_in;
    logic [XLEN-1:0]   alu_data_in;
    logic              lsu_valid_in;
    logic              lsu_ready_out;
    logic [REG_AW-1:0] lsu_rd_in;
    logic [XLEN-1:0]   lsu_data_in;
    logic              wb_valid_out;
    logic              wb_ready_in;
    logic [REG_AW-1:0] wb_rd_out;
    logic [XLEN-1:0]   wb_data_out;
    logic [REG_AW-1:0] rs1_addr_in;
    logic [REG_AW-1:0] rs2_addr_in;
    logic              rs1_pending_out;
    logic              rs2_pending_out;

    wb_arbiter_queue #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH)
    ) dut (
        .clock_in        (clock_in),
        .reset_in        (reset_in),
        .alu_valid_in    (alu_valid_in),
        .alu_ready_out   (alu_ready_out),
        .alu_rd_in       (alu_rd_in),
        .alu_data_in     (alu_data_in),
        .lsu_valid_in    (lsu_valid_in),
        .lsu_ready_out   (lsu_ready_out),
        .lsu_rd_in       (lsu_rd_in),
        .lsu_data_in     (lsu_data_in),
        .wb_valid_out    (wb_valid_out),
        .wb_ready_in     (wb_ready_in),
        .wb_rd_out       (wb_rd_out),
        .wb_data_out     (wb_data_out),
        .rs1_addr_in     (rs1_addr_in),
        .rs2_addr_in     (rs2_addr_in),
        .rs1_pending_out (rs1_pending_out),
        .rs2_pending_out (rs2_pending_out)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic        wbr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        e_ar;
        logic        e_lr;
        logic        e_v;
        logic [4:0]  e_rd;
        logic [31:0] e_dat;
        logic        e_p1;
        logic        e_p2;
    } vec_t;

    vec_t vecs[10];

    int checks = 0;
    int errors = 0;

    // Reference model: the queue contents in order, who won the last accepted
    // transfer, and what the output port is currently showing.
    wb_entry_t   model_q[$];
    bit          last_alu;
    logic [4:0]  shown_rd;
    logic [31:0] shown_data;
    bit          alu_acc;
    bit          lsu_acc;

    logic        tr_av;
    logic [4:0]  tr_ard;
    logic [31:0] tr_adat;
    logic        tr_lv;
    logic [4:0]  tr_lrd;
    logic [31:0] tr_ldat;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic driveInputs(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                               input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                               input logic wbr, input logic [4:0] rs1, input logic [4:0] rs2);
        alu_valid_in = av;
        alu_rd_in    = ard;
        alu_data_in  = adat;
        lsu_valid_in = lv;
        lsu_rd_in    = lrd;
        lsu_data_in  = ldat;
        wb_ready_in  = wbr;
        rs1_addr_in  = rs1;
        rs2_addr_in  = rs2;
    endtask

    task automatic modelReset();
        model_q.delete();
        last_alu   = 1'b0;
        shown_rd   = '0;
        shown_data = '0;
        tr_av      = 1'b0;
        tr_lv      = 1'b0;
    endtask

    // One cycle: drive at the falling edge, check just after, then advance the
    // model across the rising edge and return to the next falling edge.
    task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                                 input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                                 input logic wbr, input logic [4:0] rs1, input logic [4:0] rs2);
        int        n;
        bit        pop_e;
        bit        alu_wins;
        bit        acc;
        bit        p1;
        bit        p2;
        logic [4:0] wrd;
        wb_entry_t e;
        driveInputs(av, ard, adat, lv, lrd, ldat, wbr, rs1, rs2);
        #1;
        n        = model_q.size();
        pop_e    = (n > 0) && wbr;
        alu_wins = (av && lv) ? !last_alu : av;
        wrd      = alu_wins ? ard : lrd;
        acc      = (av || lv) && ((wrd == 5'd0) || (n < DEPTH) || pop_e);
        if (n > 0) begin
            shown_rd   = model_q[0].rd;
            shown_data = model_q[0].data;
        end
        p1 = 1'b0;
        p2 = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (rs1 != 5'd0 && model_q[i].rd == rs1) p1 = 1'b1;
            if (rs2 != 5'd0 && model_q[i].rd == rs2) p2 = 1'b1;
        end
        checkOutput("alu_ready", alu_ready_out, acc && alu_wins);
        checkOutput("lsu_ready", lsu_ready_out, acc && !alu_wins);
        checkOutput("wb_valid", wb_valid_out, n > 0);
        checkOutput("wb_rd", wb_rd_out, shown_rd);
        checkOutput("wb_data", wb_data_out, shown_data);
        checkOutput("rs1_pending", rs1_pending_out, p1);
        checkOutput("rs2_pending", rs2_pending_out, p2);
        alu_acc = acc && alu_wins;
        lsu_acc = acc && !alu_wins;
        @(posedge clock_in);
        if (pop_e) void'(model_q.pop_front());
        if (acc && wrd != 5'd0) begin
            e.rd   = wrd;
            e.data = alu_wins ? adat : ldat;
            model_q.push_back(e);
        end
        if (acc) last_alu = alu_wins;
        @(negedge clock_in);
    endtask

    // Reset held with both producers requesting; outputs must stay quiet.
    task automatic doReset();
        reset_in = 1'b0;
        driveInputs(1'b1, 5'd3, 32'h3333, 1'b1, 5'd4, 32'h4444, 1'b1, 5'd3, 5'd4);
        @(posedge clock_in);
        @(negedge clock_in);
        #1;
        checkOutput("rst_alu_ready", alu_ready_out, 0);
        checkOutput("rst_lsu_ready", lsu_ready_out, 0);
        checkOutput("rst_wb_valid", wb_valid_out, 0);
        checkOutput("rst_wb_rd", wb_rd_out, 0);
        checkOutput("rst_wb_data", wb_data_out, 0);
        checkOutput("rst_rs1_pending", rs1_pending_out, 0);
        checkOutput("rst_rs2_pending", rs2_pending_out, 0);
        @(negedge clock_in);
        reset_in = 1'b1;
        modelReset();
    endtask

    // Producers keep a request (valid, rd, data) stable until it is accepted.
    task automatic runTraffic(input int cycles, input int alu_pct, input int lsu_pct,
                              input int wbr_pct);
        logic wbr;
        for (int c = 0; c < cycles; c++) begin
            if (!tr_av) begin
                tr_av   = int'($urandom_range(0, 99)) < alu_pct;
                tr_ard  = 5'($urandom_range(0, 31));
                tr_adat = $urandom;
            end
            if (!tr_lv) begin
                tr_lv   = int'($urandom_range(0, 99)) < lsu_pct;
                tr_lrd  = 5'($urandom_range(0, 31));
                tr_ldat = $urandom;
            end
            wbr = int'($urandom_range(0, 99)) < wbr_pct;
            applyStimulus(tr_av, tr_ard, tr_adat, tr_lv, tr_lrd, tr_ldat, wbr,
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            if (alu_acc) tr_av = 1'b0;
            if (lsu_acc) tr_lv = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_in = 1'b0;
        modelReset();
        driveInputs(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);

        vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b1, 5'd5, 5'd0,
                    1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0};
        vecs[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd5, 5'd5,
                    1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd5, 5'd0,
                    1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22, 1'b0, 5'd1, 5'd2,
                    1'b0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd3, 32'h33, 1'b0, 5'd2, 5'd1,
                    1'b1, 1'b0, 1'b1, 5'd2, 32'h22,       1'b1, 1'b0};
        vecs[5] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'h33, 1'b1, 5'd1, 5'd3,
                    1'b0, 1'b1, 1'b1, 5'd2, 32'h22,       1'b1, 1'b0};
        vecs[6] = '{1'b1, 5'd0, 32'h99,       1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd3,
                    1'b1, 1'b0, 1'b1, 5'd1, 32'h11,       1'b0, 1'b1};
        vecs[7] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd1, 5'd3,
                    1'b0, 1'b0, 1'b1, 5'd1, 32'h11,       1'b1, 1'b1};
        vecs[8] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd1, 5'd3,
                    1'b0, 1'b0, 1'b1, 5'd3, 32'h33,       1'b0, 1'b1};
        vecs[9] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd1, 5'd3,
                    1'b0, 1'b0, 1'b0, 5'd3, 32'h33,       1'b0, 1'b0};

        @(negedge clock_in);
        doReset();

        $display("[TB] vector table");
        for (int i = 0; i < 10; i++) begin
            driveInputs(vecs[i].av, vecs[i].ard, vecs[i].adat, vecs[i].lv, vecs[i].lrd,
                        vecs[i].ldat, vecs[i].wbr, vecs[i].rs1, vecs[i].rs2);
            #1;
            checkOutput($sformatf("vec%0d_alu_ready", i), alu_ready_out, vecs[i].e_ar);
            checkOutput($sformatf("vec%0d_lsu_ready", i), lsu_ready_out, vecs[i].e_lr);
            checkOutput($sformatf("vec%0d_wb_valid", i), wb_valid_out, vecs[i].e_v);
            checkOutput($sformatf("vec%0d_wb_rd", i), wb_rd_out, vecs[i].e_rd);
            checkOutput($sformatf("vec%0d_wb_data", i), wb_data_out, vecs[i].e_dat);
            checkOutput($sformatf("vec%0d_rs1_pending", i), rs1_pending_out, vecs[i].e_p1);
            checkOutput($sformatf("vec%0d_rs2_pending", i), rs2_pending_out, vecs[i].e_p2);
            @(posedge clock_in);
            @(negedge clock_in);
        end

        $display("[TB] fill to depth, blocked fifth push, pop-through, drain");
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 5'(i + 1), 32'hA0 + i, 1'b0, 5'd0, 32'd0, 1'b0, 5'(i + 1), 5'd5);
        end
        applyStimulus(1'b1, 5'd5, 32'hA4, 1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 5'd5);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 5'd5);
        end

        $display("[TB] alternating grants with both producers busy");
        doReset();
        runTraffic(8, 100, 100, 100);

        $display("[TB] reset in the middle of queued traffic");
        runTraffic(10, 80, 80, 0);
        doReset();

        $display("[TB] random traffic");
        runTraffic(150, 60, 60, 70);
        runTraffic(100, 90, 90, 25);
        runTraffic(100, 30, 30, 90);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
